// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: SEG carry bits resolved per stage, valid/ready with global-enable stall.
// Optional macro PIPE_ADDER_SAT_EN clamps sum to the signed range on overflow.
module pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned MSB    = WIDTH - 1;
  localparam int unsigned SW     = SEG + 1;

  logic                adv;
  logic [STAGES-1:0]   vld_q;
  logic [STAGES-1:0]   cy_q;
  logic [WIDTH-1:0]    a_q   [STAGES];
  logic [WIDTH-1:0]    b_q   [STAGES];
  logic [WIDTH-1:0]    s_q   [STAGES];
  logic [WIDTH-1:0]    s_nxt [STAGES];
  logic [SEG:0]        seg_res [STAGES];
  logic [WIDTH-1:0]    raw_sum;
  logic [WIDTH-1:0]    sum_nxt;
  logic                ovf_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k resolves slice k using the carry registered into that stage
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_res[k] = SW'(a_q[k][k*SEG +: SEG]) + SW'(b_q[k][k*SEG +: SEG]) + SW'(cy_q[k]);
      s_nxt[k]   = s_q[k];
      s_nxt[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
    end
  end

  // Final-stage overflow detection and optional clamp
  always_comb begin
    raw_sum = s_nxt[LAST];
    ovf_nxt = (a_q[LAST][MSB] == b_q[LAST][MSB]) && (raw_sum[MSB] != a_q[LAST][MSB]);
    sum_nxt = raw_sum;
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_nxt) begin
      sum_nxt = a_q[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      cy_q      <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= b;
      cy_q[0]  <= c_in;
      s_q[0]   <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        cy_q[k]  <= seg_res[k-1][SEG];
        s_q[k]   <= s_nxt[k-1];
      end
      out_valid <= vld_q[LAST];
      // Result registers only move on a real beat so they hold the last result across bubbles
      if (vld_q[LAST]) begin
        sum   <= sum_nxt;
        c_out <= seg_res[LAST][SEG];
        ovf   <= ovf_nxt;
      end
    end
  end

endmodule
